bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_if.sv | 25 ++
 rtl/bus_arbiter_rr_pick.sv | 22 ++
 rtl/bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master split-capable bus arbiter.
package bus_arb_pkg;

    localparam int N_MASTERS = 2;
    localparam int DEF_TOUT  = 64;
    localparam int DEF_CW    = 7;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_SPLIT_WAIT = 2'd2,
        ST_RESUME     = 2'd3
    } arb_state_e;

    function automatic logic [N_MASTERS-1:0] onehot(input logic idx);
        onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bus-side signals of the arbiter: requests, slave hold, grants and status flags.
interface bus_arbiter_if;
    import bus_arb_pkg::*;

    logic [N_MASTERS-1:0] req;
    logic                 slave_hold;
    logic [N_MASTERS-1:0] grant;
    logic                 bus_available;
    logic                 split_pending;
    logic                 timeout_err;
    arb_state_e           dbg_state;

    // Handshake: a master holds req high for its whole transaction; the arbiter
    // owns the bus for it while grant[m] is high, and a one-cycle req drop ends it.
    modport slave (
        input  req, slave_hold,
        output grant, bus_available, split_pending, timeout_err, dbg_state
    );

    modport master (
        output req, slave_hold,
        input  grant, bus_available, split_pending, timeout_err, dbg_state
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational two-way round-robin picker; returns a one-hot selection or zero.
module arb_rr_pick
    import bus_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [N_MASTERS-1:0] mask_i,
    input  logic                 last_owner_i,
    output logic [N_MASTERS-1:0] sel_o
);

    logic [N_MASTERS-1:0] eligible;

    always_comb begin
        eligible = req_i & ~mask_i;
        sel_o    = eligible;
        // On contention, hand the bus to whichever master did not own it last.
        if (eligible == 2'b11) begin
            sel_o = last_owner_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with split-transaction parking and resume.
// Optional grant watchdog enabled by defining ARB_WATCHDOG_EN.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int TOUT = DEF_TOUT,
    parameter int CW   = DEF_CW
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);

    if (2 ** CW <= TOUT) begin : g_cw_check
        $error("bus_arbiter: CW too narrow to count to TOUT");
    end

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_owner_q, last_owner_d;
    logic                 split_owner_q, split_owner_d;
    logic                 split_pending_q, split_pending_d;
    logic                 hold_fell_q, hold_fell_d;
    logic                 hold_prev_q;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic                 bus_avail_q, bus_avail_d;

    logic [N_MASTERS-1:0] park_mask;
    logic [N_MASTERS-1:0] pick;
    logic                 hold_rise, hold_fall;
    logic                 resume_ok, cancel_split;

    assign park_mask    = split_pending_q ? onehot(split_owner_q) : 2'b00;
    assign hold_rise    = bus.slave_hold & ~hold_prev_q;
    assign hold_fall    = ~bus.slave_hold & hold_prev_q;
    // A parked master giving up its request abandons the split.
    assign cancel_split = split_pending_q && (state_q != ST_RESUME) && !bus.req[split_owner_q];
    assign resume_ok    = split_pending_q && bus.req[split_owner_q] &&
                          (!bus.slave_hold || hold_fell_q);

    arb_rr_pick u_pick (
        .req_i        (bus.req),
        .mask_i       (park_mask),
        .last_owner_i (last_owner_q),
        .sel_o        (pick)
    );

`ifdef ARB_WATCHDOG_EN
    logic [CW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
    logic          wd_active;

    assign wd_active = (state_q == ST_GRANT) || (state_q == ST_RESUME);
`endif

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_owner_d    = last_owner_q;
        split_owner_d   = split_owner_q;
        split_pending_d = split_pending_q;
        hold_fell_d     = hold_fell_q | (split_pending_q & hold_fall);
        grant_d         = grant_q;
        bus_avail_d     = bus_avail_q;

        if (cancel_split) begin
            split_pending_d = 1'b0;
            hold_fell_d     = 1'b0;
        end

        unique case (state_q)
            ST_IDLE, ST_SPLIT_WAIT: begin
                grant_d     = 2'b00;
                bus_avail_d = 1'b0;
                if (resume_ok) begin
                    state_d     = ST_RESUME;
                    grant_d     = onehot(split_owner_q);
                    bus_avail_d = 1'b1;
                    hold_fell_d = 1'b0;
                end else if (pick != 2'b00) begin
                    state_d = ST_GRANT;
                    owner_d = pick[1];
                    grant_d = pick;
                end else if (state_q == ST_SPLIT_WAIT && !split_pending_d) begin
                    state_d = ST_IDLE;
                end
            end

            ST_GRANT: begin
                if (!bus.req[owner_q]) begin
                    grant_d      = 2'b00;
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end else if (hold_rise && !split_pending_q) begin
                    split_pending_d = 1'b1;
                    split_owner_d   = owner_q;
                    hold_fell_d     = 1'b0;
                    grant_d         = 2'b00;
                    last_owner_d    = owner_q;
                    state_d         = bus.req[~owner_q] ? ST_IDLE : ST_SPLIT_WAIT;
                end else begin
                    grant_d = onehot(owner_q);
                end
            end

            ST_RESUME: begin
                if (!bus.req[split_owner_q]) begin
                    grant_d         = 2'b00;
                    bus_avail_d     = 1'b0;
                    split_pending_d = 1'b0;
                    hold_fell_d     = 1'b0;
                    last_owner_d    = split_owner_q;
                    state_d         = ST_IDLE;
                end else begin
                    grant_d     = onehot(split_owner_q);
                    bus_avail_d = 1'b1;
                end
            end
        endcase

`ifdef ARB_WATCHDOG_EN
        timeout_d = 1'b0;
        wd_d      = '0;
        if (wd_active && wd_q == CW'(TOUT)) begin
            state_d      = ST_IDLE;
            grant_d      = 2'b00;
            bus_avail_d  = 1'b0;
            last_owner_d = (state_q == ST_RESUME) ? split_owner_q : owner_q;
            if (state_q == ST_RESUME) begin
                split_pending_d = 1'b0;
                hold_fell_d     = 1'b0;
            end
        end else begin
            // Raised one cycle ahead so the pulse lines up with the expiry cycle.
            timeout_d = wd_active && (state_d == state_q) && (wd_q == CW'(TOUT - 1));
        end
        if (wd_active && state_d == state_q) begin
            wd_d = wd_q + CW'(1);
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            split_owner_q   <= 1'b0;
            split_pending_q <= 1'b0;
            hold_fell_q     <= 1'b0;
            hold_prev_q     <= 1'b0;
            grant_q         <= 2'b00;
            bus_avail_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_owner_q    <= last_owner_d;
            split_owner_q   <= split_owner_d;
            split_pending_q <= split_pending_d;
            hold_fell_q     <= hold_fell_d;
            hold_prev_q     <= bus.slave_hold;
            grant_q         <= grant_d;
            bus_avail_q     <= bus_avail_d;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant         = grant_q;
    assign bus.bus_available = bus_avail_q;
    assign bus.split_pending = split_pending_q;
    assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table plus split, reset and watchdog sequences.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    bus_arbiter_if bus_if ();

    bus_arbiter #(.TOUT(8), .CW(7)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic       hold;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];

    task automatic add(input logic r, input logic [1:0] q, input logic h,
                       input logic [1:0] g, input logic b, input logic s, input logic t);
        vec_t v;
        v.rst  = r;
        v.req  = q;
        v.hold = h;
        v.exp  = {g, b, s, t};
        vecs.push_back(v);
    endtask

    function automatic logic [4:0] dut_out();
        return {bus_if.grant, bus_if.bus_available, bus_if.split_pending, bus_if.timeout_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = dut_out();
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grant=%b bav=%b sp=%b to=%b, want grant=%b bav=%b sp=%b to=%b",
                     name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic check_q(input string name);
        logic [4:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: got empty expected queue, want one entry", name);
        end else begin
            exp = exp_q.pop_front();
            check(name, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_if.req = 2'b00;
        bus_if.slave_hold = 1'b0;

        //   rst req    hold grant bav sp to
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);  // 0 reset values
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);  // single requester granted
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);  // release
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);  // 5 reset: last owner = master 1
        add(0, 2'b11, 0, 2'b01, 0, 0, 0);  // rr picks master 0 first
        add(0, 2'b11, 0, 2'b01, 0, 0, 0);
        add(0, 2'b10, 0, 2'b00, 0, 0, 0);  // master 0 drops one cycle
        add(0, 2'b11, 0, 2'b10, 0, 0, 0);  // alternate to master 1
        add(0, 2'b11, 0, 2'b10, 0, 0, 0);  // 10
        add(0, 2'b01, 0, 2'b00, 0, 0, 0);
        add(0, 2'b11, 0, 2'b01, 0, 0, 0);  // back to master 0
        add(0, 2'b10, 0, 2'b00, 0, 0, 0);
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(1, 2'b00, 0, 2'b00, 0, 0, 0);  // 15 split with other master waiting
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);
        add(0, 2'b11, 1, 2'b00, 0, 1, 0);  // hold rises: park master 0
        add(0, 2'b11, 1, 2'b10, 0, 1, 0);  // master 1 granted
        add(0, 2'b11, 0, 2'b10, 0, 1, 0);  // hold falls during other grant
        add(0, 2'b11, 0, 2'b10, 0, 1, 0);  // 20
        add(0, 2'b01, 0, 2'b00, 0, 1, 0);  // master 1 releases
        add(0, 2'b11, 0, 2'b01, 1, 1, 0);  // resume beats new request
        add(0, 2'b11, 0, 2'b01, 1, 1, 0);
        add(0, 2'b10, 0, 2'b00, 0, 0, 0);  // resume ends
        add(0, 2'b10, 0, 2'b10, 0, 0, 0);  // 25
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);  // split with bus idle
        add(0, 2'b01, 1, 2'b00, 0, 1, 0);
        add(0, 2'b01, 1, 2'b00, 0, 1, 0);
        add(0, 2'b01, 0, 2'b01, 1, 1, 0);  // 30 resume next cycle
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);  // req drop and hold rise together
        add(0, 2'b00, 1, 2'b00, 0, 0, 0);
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);  // 35 latched fall, second rise ignored
        add(0, 2'b11, 1, 2'b00, 0, 1, 0);
        add(0, 2'b11, 1, 2'b10, 0, 1, 0);
        add(0, 2'b11, 0, 2'b10, 0, 1, 0);
        add(0, 2'b11, 1, 2'b10, 0, 1, 0);
        add(0, 2'b01, 1, 2'b00, 0, 1, 0);  // 40
        add(0, 2'b01, 1, 2'b01, 1, 1, 0);  // resume from latched fall
        add(0, 2'b00, 1, 2'b00, 0, 0, 0);
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);
        add(0, 2'b01, 0, 2'b01, 0, 0, 0);  // parked master cancels
        add(0, 2'b01, 1, 2'b00, 0, 1, 0);  // 45
        add(0, 2'b00, 1, 2'b00, 0, 0, 0);
        add(0, 2'b00, 0, 2'b00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst;
            bus_if.req = vecs[i].req;
            bus_if.slave_hold = vecs[i].hold;
            exp_q.push_back(vecs[i].exp);
            step();
            check_q($sformatf("vec%0d", i));
            if (i == 0) begin
                n_checks++;
                if (bus_if.dbg_state === ST_IDLE) n_pass++;
                else $display("FAIL reset_state: got %0d, want %0d", bus_if.dbg_state, ST_IDLE);
            end
        end

        // Reset asserted in the middle of a resume.
        rst = 1'b1; bus_if.req = 2'b00; bus_if.slave_hold = 1'b0;
        step();
        rst = 1'b0; bus_if.req = 2'b01;
        step(); check("rm_grant", 5'b01_0_0_0);
        bus_if.slave_hold = 1'b1;
        step(); check("rm_park", 5'b00_0_1_0);
        bus_if.slave_hold = 1'b0;
        step(); check("rm_resume", 5'b01_1_1_0);
        #3 rst = 1'b1;
        #1 check("rm_async", 5'b00_0_0_0);
        step(); check("rm_held", 5'b00_0_0_0);
        rst = 1'b0;
        step(); check("rm_rearb", 5'b01_0_0_0);
        bus_if.req = 2'b00;
        step(); check("rm_release", 5'b00_0_0_0);

        // Grant held far longer than the watchdog limit.
        bus_if.req = 2'b01;
`ifdef ARB_WATCHDOG_EN
        for (int k = 1; k <= 11; k++) begin
            step();
            check($sformatf("wd_%0d", k), {(k == 10) ? 2'b00 : 2'b01, 1'b0, 1'b0, (k == 9) ? 1'b1 : 1'b0});
        end
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("nowd_%0d", k), 5'b01_0_0_0);
        end
`endif
        bus_if.req = 2'b00;
        step(); check("final_idle", 5'b00_0_0_0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
